// File: rtl/gigatron_fetch.sv
// Gigatron instruction-fetch stage: PC sequencing, single-delay-slot branches, stall replay.
// Optional instruction counter output o_ins_count enabled by defining GIGATRON_FETCH_PERF_EN.
module gigatron_fetch #(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_stall,
  input  logic                  i_branch,
  input  logic [ADDR_WIDTH-1:0] i_branch_addr,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  input  logic [15:0]           i_rom_data,
  output logic [15:0]           o_ins,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic                  o_valid
`ifdef GIGATRON_FETCH_PERF_EN
  ,
  output logic [31:0]           o_ins_count
`endif
);

  localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] r_ins_pc;
  logic [ADDR_WIDTH-1:0] r_seq_pc;
  logic                  r_valid;
  logic [ADDR_WIDTH-1:0] w_rom_addr;
  logic [ADDR_WIDTH-1:0] w_seq_next;

  // A stalled instruction re-reads its own word so the registered ROM output stays put.
  always_comb begin
    w_rom_addr = r_seq_pc;
    if (!i_reset_n) begin
      w_rom_addr = RESET_PC;
    end else if (r_valid && i_stall) begin
      w_rom_addr = r_ins_pc;
    end
  end

  assign w_seq_next = w_rom_addr + ONE;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_valid  <= 1'b0;
      r_ins_pc <= RESET_PC;
      r_seq_pc <= RESET_PC;
    end else if (!r_valid) begin
      r_valid  <= 1'b1;
      r_ins_pc <= w_rom_addr;
      r_seq_pc <= w_seq_next;
    end else if (!i_stall) begin
      // The word fetched now is the delay slot; the target follows it.
      r_ins_pc <= w_rom_addr;
      r_seq_pc <= i_branch ? i_branch_addr : w_seq_next;
    end
  end

`ifdef GIGATRON_FETCH_PERF_EN
  logic [31:0] r_ins_count;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_ins_count <= 32'd0;
    end else if (r_valid && !i_stall) begin
      r_ins_count <= r_ins_count + 32'd1;
    end
  end

  assign o_ins_count = r_ins_count;
`endif

  assign o_rom_addr = w_rom_addr;
  assign o_ins      = i_rom_data;
  assign o_pc       = r_ins_pc;
  assign o_valid    = r_valid;

endmodule

// File: tb/tb_gigatron_fetch.sv
// Self-checking bench for gigatron_fetch: directed vector table, perf-counter sequence,
// and randomized traffic against an instruction-stream reference model.
module tb_gigatron_fetch;

  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clock = 1'b0;
  logic        rstN;
  logic        stall;
  logic        branch;
  logic [15:0] branchAddr;
  logic [15:0] romAddr;
  logic [15:0] romData;
  logic [15:0] ins;
  logic [15:0] pc;
  logic        valid;
`ifdef GIGATRON_FETCH_PERF_EN
  logic [31:0] insCount;
`endif

  int total = 0;
  int bad   = 0;

  // ROM contents are address XOR a key; key 0 gives "word = address".
  logic [15:0] romXor = 16'h0000;

  // Reference model: the instruction currently shown and the one that follows it.
  logic        mKnown = 1'b0;
  logic        mValid;
  logic [15:0] mPc;
  logic [15:0] mFollow;
  logic [31:0] mCount;

  typedef struct {
    logic        rstN;
    logic        stall;
    logic        branch;
    logic [15:0] addr;
    logic        chk;
    logic        expValid;
    logic [15:0] expPc;
    logic [15:0] expRom;
  } vec_t;

  vec_t vecs[$];

  always #5 clock = ~clock;

  always @(posedge clock) romData <= romAddr ^ romXor;

  gigatron_fetch #(
    .ADDR_WIDTH(16),
    .RESET_PC  (RESET_PC)
  ) dut (
    .i_clock      (clock),
    .i_reset_n    (rstN),
    .i_stall      (stall),
    .i_branch     (branch),
    .i_branch_addr(branchAddr),
    .o_rom_addr   (romAddr),
    .i_rom_data   (romData),
    .o_ins        (ins),
    .o_pc         (pc),
    .o_valid      (valid)
`ifdef GIGATRON_FETCH_PERF_EN
    ,
    .o_ins_count  (insCount)
`endif
  );

  function automatic vec_t mk(logic r, logic s, logic b, logic [15:0] a,
                              logic c, logic v, logic [15:0] p, logic [15:0] ra);
    vec_t t;
    t.rstN = r; t.stall = s; t.branch = b; t.addr = a;
    t.chk = c; t.expValid = v; t.expPc = p; t.expRom = ra;
    return t;
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive this cycle's inputs and check outputs at the falling edge.
  task automatic applyStimulus(input logic r, input logic s, input logic b, input logic [15:0] a);
    rstN = r; stall = s; branch = b; branchAddr = a;
    @(negedge clock);
    checkOutput();
  endtask

  task automatic checkOutput();
    logic [15:0] expRom;
    if (mKnown) begin
      compare("valid", valid, mValid);
      compare("pc", pc, mPc);
      if (mValid) compare("ins", ins, mPc ^ romXor);
      if (!rstN)                expRom = RESET_PC;
      else if (mValid && stall) expRom = mPc;
      else                      expRom = mFollow;
      compare("rom_addr", romAddr, expRom);
`ifdef GIGATRON_FETCH_PERF_EN
      compare("ins_count", insCount, mCount);
`endif
    end
  endtask

  // Step the model across the rising edge using the inputs held this cycle.
  task automatic advance();
    @(posedge clock);
    if (!rstN) begin
      mKnown = 1'b1; mValid = 1'b0; mPc = RESET_PC; mFollow = RESET_PC; mCount = 0;
    end else if (mKnown) begin
      if (!mValid) begin
        mValid  = 1'b1;
        mPc     = mFollow;
        mFollow = mPc + 16'd1;
      end else if (!stall) begin
        mCount  = mCount + 1;
        mPc     = mFollow;
        mFollow = branch ? branchAddr : mPc + 16'd1;
      end
    end
    #1;
  endtask

  initial begin
    rstN = 1'b0; stall = 1'b0; branch = 1'b0; branchAddr = 16'h0000;

    // rstN stall branch addr | chk valid pc rom
    vecs.push_back(mk(0,0,0,16'h0000, 0,0,16'h0000,16'h0000));
    vecs.push_back(mk(0,0,0,16'h0000, 1,0,16'h0000,16'h0000));
    vecs.push_back(mk(1,0,0,16'h0000, 1,0,16'h0000,16'h0000));
    vecs.push_back(mk(1,0,0,16'h0000, 1,1,16'h0000,16'h0001));
    vecs.push_back(mk(1,0,0,16'h0000, 1,1,16'h0001,16'h0002));
    vecs.push_back(mk(1,0,0,16'h0000, 1,1,16'h0002,16'h0003));
    vecs.push_back(mk(1,0,0,16'h0000, 1,1,16'h0003,16'h0004));
    vecs.push_back(mk(1,0,0,16'h0000, 1,1,16'h0004,16'h0005));
    vecs.push_back(mk(1,0,1,16'h0100, 1,1,16'h0005,16'h0006));
    vecs.push_back(mk(1,0,0,16'h0000, 1,1,16'h0006,16'h0100));
    vecs.push_back(mk(1,0,0,16'h0000, 1,1,16'h0100,16'h0101));
    vecs.push_back(mk(1,0,1,16'h0010, 1,1,16'h0101,16'h0102));
    vecs.push_back(mk(1,0,0,16'h0000, 1,1,16'h0102,16'h0010));
    vecs.push_back(mk(1,1,0,16'h0000, 1,1,16'h0010,16'h0010));
    vecs.push_back(mk(1,1,0,16'h0000, 1,1,16'h0010,16'h0010));
    vecs.push_back(mk(1,1,0,16'h0000, 1,1,16'h0010,16'h0010));
    vecs.push_back(mk(1,0,0,16'h0000, 1,1,16'h0010,16'h0011));
    vecs.push_back(mk(1,0,1,16'h0020, 1,1,16'h0011,16'h0012));
    vecs.push_back(mk(1,0,0,16'h0000, 1,1,16'h0012,16'h0020));
    vecs.push_back(mk(1,1,1,16'h0200, 1,1,16'h0020,16'h0020));
    vecs.push_back(mk(1,0,0,16'h0000, 1,1,16'h0020,16'h0021));
    vecs.push_back(mk(1,0,0,16'h0000, 1,1,16'h0021,16'h0022));
    vecs.push_back(mk(1,0,1,16'hFFFE, 1,1,16'h0022,16'h0023));
    vecs.push_back(mk(1,0,0,16'h0000, 1,1,16'h0023,16'hFFFE));
    vecs.push_back(mk(1,0,0,16'h0000, 1,1,16'hFFFE,16'hFFFF));
    vecs.push_back(mk(1,0,0,16'h0000, 1,1,16'hFFFF,16'h0000));
    vecs.push_back(mk(1,0,0,16'h0000, 1,1,16'h0000,16'h0001));
    vecs.push_back(mk(1,1,0,16'h0000, 1,1,16'h0001,16'h0001));
    vecs.push_back(mk(0,1,1,16'h0300, 1,1,16'h0001,16'h0000));
    vecs.push_back(mk(1,0,0,16'h0000, 1,0,16'h0000,16'h0000));
    vecs.push_back(mk(1,0,0,16'h0000, 1,1,16'h0000,16'h0001));
    vecs.push_back(mk(1,0,1,16'h0040, 1,1,16'h0001,16'h0002));
    vecs.push_back(mk(1,0,1,16'h0080, 1,1,16'h0002,16'h0040));
    vecs.push_back(mk(1,0,0,16'h0000, 1,1,16'h0040,16'h0080));
    vecs.push_back(mk(1,0,0,16'h0000, 1,1,16'h0080,16'h0081));

    $display("[TB] directed vectors: %0d", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].stall, vecs[i].branch, vecs[i].addr);
      if (vecs[i].chk) begin
        compare($sformatf("vec%0d.valid", i), valid, vecs[i].expValid);
        compare($sformatf("vec%0d.pc", i), pc, vecs[i].expPc);
        compare($sformatf("vec%0d.rom", i), romAddr, vecs[i].expRom);
        if (vecs[i].expValid) compare($sformatf("vec%0d.ins", i), ins, vecs[i].expPc);
      end
      advance();
    end

`ifdef GIGATRON_FETCH_PERF_EN
    $display("[TB] perf counter sequence");
    for (int i = 0; i < 2; i++) begin applyStimulus(0, 0, 0, 16'h0000); advance(); end
    for (int i = 0; i < 11; i++) begin applyStimulus(1, 0, 0, 16'h0000); advance(); end
    for (int i = 0; i < 3; i++) begin applyStimulus(1, 1, 0, 16'h0000); advance(); end
    @(negedge clock);
    compare("perf.after_stall", insCount, 32'd10);
    applyStimulus(0, 0, 0, 16'h0000); advance();
    @(negedge clock);
    compare("perf.after_reset", insCount, 32'd0);
`endif

    $display("[TB] randomized traffic");
    applyStimulus(0, 0, 0, 16'h0000); advance();
    romXor = 16'hC3A5;
    applyStimulus(0, 0, 0, 16'h0000); advance();
    for (int i = 0; i < 400; i++) begin
      logic        r, s, b;
      logic [15:0] a;
      r = ($urandom_range(0, 59) != 0);
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 4) == 0);
      a = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF))
                                      : 16'($urandom);
      applyStimulus(r, s, b, a);
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
